// File: rtl/hcms_frame_feeder.sv
// Streams a NUM_CHARS character buffer through a 5x7 column font as dot bytes to an hcms_serial stage.
// Define HCMS_CTRL_WORD_EN to prepend one control-word byte (RS_o=1) to every frame.
module hcms_frame_feeder #(
  parameter int          NUM_CHARS    = 4,
  parameter logic [3:0]  BRIGHTNESS   = 4'hF,
  parameter logic [1:0]  PEAK_CURRENT = 2'b10,
  localparam int         AW           = $clog2(NUM_CHARS)
) (
  input  logic          CLK_i,
  input  logic          RSTn_i,
  input  logic          CHAR_WE_i,
  input  logic [AW-1:0] CHAR_ADDR_i,
  input  logic [7:0]    CHAR_i,
  input  logic          START_i,
  output logic [7:0]    DATA_o,
  output logic          DATA_LOAD_o,
  input  logic          SER_READY_i,
  output logic          RS_o,
  output logic          BUSY_o,
  output logic          DONE_o
);

  // state   | meaning
  // IDLE    | waiting for START_i; with BUSY_o already set it is the one-cycle launch step
  // CTRL    | presenting the control word (only with HCMS_CTRL_WORD_EN)
  // FETCH   | font ROM read for (char index, column)
  // PRESENT | DATA_LOAD_o high, holding the byte until SER_READY_i
  // DONE    | one-cycle DONE_o pulse
`ifdef HCMS_CTRL_WORD_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE, S_CTRL} state_e;
  localparam state_e     S_FIRST   = S_CTRL;
  localparam logic [7:0] CTRL_BYTE = {1'b0, 1'b1, PEAK_CURRENT, BRIGHTNESS};
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_e;
  localparam state_e     S_FIRST   = S_FETCH;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CHARS - 1);

  state_e        state_q;
  logic [7:0]    data_q;
  logic          load_q;
  logic          rs_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] idx_q;
  logic [2:0]    col_q;
  logic [7:0]    buf_q [NUM_CHARS];

  // Glyph columns packed left to right, column 0 in the top byte; bit0 is the top row.
  function automatic logic [39:0] glyph(input logic [7:0] code);
    logic [7:0] c;
    c = code;
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    case (c)
      8'h20: glyph = 40'h0000000000;
      8'h21: glyph = 40'h00005F0000;
      8'h22: glyph = 40'h0007000700;
      8'h23: glyph = 40'h147F147F14;
      8'h24: glyph = 40'h242A7F2A12;
      8'h25: glyph = 40'h2313086462;
      8'h26: glyph = 40'h3649552250;
      8'h27: glyph = 40'h0005030000;
      8'h28: glyph = 40'h001C224100;
      8'h29: glyph = 40'h0041221C00;
      8'h2A: glyph = 40'h14083E0814;
      8'h2B: glyph = 40'h08083E0808;
      8'h2C: glyph = 40'h0050300000;
      8'h2D: glyph = 40'h0808080808;
      8'h2E: glyph = 40'h0060600000;
      8'h2F: glyph = 40'h2010080402;
      8'h30: glyph = 40'h3E5149453E;
      8'h31: glyph = 40'h00427F4000;
      8'h32: glyph = 40'h4261514946;
      8'h33: glyph = 40'h2141454B31;
      8'h34: glyph = 40'h1814127F10;
      8'h35: glyph = 40'h2745454539;
      8'h36: glyph = 40'h3C4A494930;
      8'h37: glyph = 40'h0171090503;
      8'h38: glyph = 40'h3649494936;
      8'h39: glyph = 40'h064949291E;
      8'h3A: glyph = 40'h0036360000;
      8'h3B: glyph = 40'h0056360000;
      8'h3C: glyph = 40'h0814224100;
      8'h3D: glyph = 40'h1414141414;
      8'h3E: glyph = 40'h0041221408;
      8'h3F: glyph = 40'h0201510906;
      8'h40: glyph = 40'h324979413E;
      8'h41: glyph = 40'h7E1111117E;
      8'h42: glyph = 40'h7F49494936;
      8'h43: glyph = 40'h3E41414122;
      8'h44: glyph = 40'h7F4141221C;
      8'h45: glyph = 40'h7F49494941;
      8'h46: glyph = 40'h7F09090901;
      8'h47: glyph = 40'h3E4149497A;
      8'h48: glyph = 40'h7F0808087F;
      8'h49: glyph = 40'h00417F4100;
      8'h4A: glyph = 40'h2040413F01;
      8'h4B: glyph = 40'h7F08142241;
      8'h4C: glyph = 40'h7F40404040;
      8'h4D: glyph = 40'h7F020C027F;
      8'h4E: glyph = 40'h7F0408107F;
      8'h4F: glyph = 40'h3E4141413E;
      8'h50: glyph = 40'h7F09090906;
      8'h51: glyph = 40'h3E4151215E;
      8'h52: glyph = 40'h7F09192946;
      8'h53: glyph = 40'h4649494931;
      8'h54: glyph = 40'h01017F0101;
      8'h55: glyph = 40'h3F4040403F;
      8'h56: glyph = 40'h1F2040201F;
      8'h57: glyph = 40'h3F4038403F;
      8'h58: glyph = 40'h6314081463;
      8'h59: glyph = 40'h0708700807;
      8'h5A: glyph = 40'h6151494543;
      8'h5B: glyph = 40'h007F414100;
      8'h5C: glyph = 40'h0204081020;
      8'h5D: glyph = 40'h0041417F00;
      8'h5E: glyph = 40'h0402010204;
      8'h5F: glyph = 40'h4040404040;
      default: glyph = 40'h0000000000;
    endcase
  endfunction

  function automatic logic [7:0] column(input logic [39:0] g, input logic [2:0] col);
    case (col)
      3'd0:    column = g[39:32];
      3'd1:    column = g[31:24];
      3'd2:    column = g[23:16];
      3'd3:    column = g[15:8];
      default: column = g[7:0];
    endcase
  endfunction

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      load_q  <= 1'b0;
      rs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      col_q   <= 3'd0;
      for (int i = 0; i < NUM_CHARS; i++) buf_q[i] <= 8'h20;
    end else begin
      done_q <= 1'b0;
      if (CHAR_WE_i && !busy_q) buf_q[CHAR_ADDR_i] <= CHAR_i;
      case (state_q)
        S_IDLE: begin
          if (busy_q) begin
            state_q <= S_FIRST;
          end else if (START_i) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            col_q  <= 3'd0;
          end
        end
`ifdef HCMS_CTRL_WORD_EN
        // First cycle loads the control word, then it obeys the same handshake as PRESENT.
        S_CTRL: begin
          if (!load_q) begin
            data_q <= CTRL_BYTE;
            rs_q   <= 1'b1;
            load_q <= 1'b1;
          end else if (SER_READY_i) begin
            load_q  <= 1'b0;
            rs_q    <= 1'b0;
            state_q <= S_FETCH;
          end
        end
`endif
        S_FETCH: begin
          data_q  <= column(glyph(buf_q[idx_q]), col_q);
          load_q  <= 1'b1;
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          if (SER_READY_i) begin
            load_q  <= 1'b0;
            state_q <= S_FETCH;
            if (col_q == 3'd4) begin
              col_q <= 3'd0;
              if (idx_q == LAST_IDX) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DATA_o      = data_q;
  assign DATA_LOAD_o = load_q;
`ifdef HCMS_CTRL_WORD_EN
  assign RS_o        = rs_q;
`else
  assign RS_o        = 1'b0;
`endif
  assign BUSY_o      = busy_q;
  assign DONE_o      = done_q;

endmodule

// File: tb/tb_hcms_frame_feeder.sv
// Directed self-checking bench for hcms_frame_feeder (NUM_CHARS=4); follows HCMS_CTRL_WORD_EN if defined.
module tb_hcms_frame_feeder;
  localparam int NC = 4;
`ifdef HCMS_CTRL_WORD_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int NB = 5 * NC + OFS;

  logic       clk = 1'b0;
  logic       rstn;
  logic       char_we;
  logic [1:0] char_addr;
  logic [7:0] char_d;
  logic       start;
  logic [7:0] data;
  logic       data_load;
  logic       ser_ready;
  logic       rs;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_d  [32];
  logic       got_rs [32];
  int n_got, first_load, done_c, hold_err;
  logic busy_c1, busy_at_done;

  always #5 clk = ~clk;

  hcms_frame_feeder #(.NUM_CHARS(NC)) dut (
    .CLK_i(clk), .RSTn_i(rstn), .CHAR_WE_i(char_we), .CHAR_ADDR_i(char_addr),
    .CHAR_i(char_d), .START_i(start), .DATA_o(data), .DATA_LOAD_o(data_load),
    .SER_READY_i(ser_ready), .RS_o(rs), .BUSY_o(busy), .DONE_o(done)
  );

  task automatic write_char(input logic [1:0] a, input logic [7:0] c);
    char_we = 1'b1; char_addr = a; char_d = c;
    @(posedge clk); #1;
    char_we = 1'b0;
  endtask

  // Pulses START (cycle 0) and records every transferred byte; cycle c is the interval after the c-th edge.
  task automatic run_frame(input int stall_byte, input int stall_len, input int inject_c);
    int stall_left;
    logic stalling;
    logic [7:0] hold_d;
    repeat (2) begin @(posedge clk); #1; end
    n_got = 0; first_load = -1; done_c = -1; hold_err = 0;
    busy_c1 = 1'b0; busy_at_done = 1'b1;
    stall_left = stall_len; stalling = 1'b0; hold_d = 8'h00;
    ser_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0; char_we = 1'b0;
      if (c == 1) busy_c1 = busy;
      if (done) begin
        done_c = c; busy_at_done = busy;
        break;
      end
      if (data_load && first_load < 0) first_load = c;
      if (c == inject_c) begin
        char_we = 1'b1; char_addr = 2'd0; char_d = 8'h5A; start = 1'b1;
      end
      if (stalling && (data !== hold_d || data_load !== 1'b1)) hold_err++;
      if (data_load && n_got == stall_byte && stall_left > 0) begin
        if (!stalling) hold_d = data;
        stalling = 1'b1;
        stall_left--;
        ser_ready = 1'b0;
      end else begin
        ser_ready = 1'b1;
        if (data_load) begin
          if (n_got < 32) begin
            got_d[n_got] = data; got_rs[n_got] = rs;
          end
          n_got++;
          stalling = 1'b0;
        end
      end
    end
    ser_ready = 1'b1; start = 1'b0; char_we = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%0h exp=0", data); end
    n_cmp++; if (data_load !== 1'b0) begin n_bad++; $display("FAIL reset_load got=%0b exp=0", data_load); end
    n_cmp++; if (rs !== 1'b0) begin n_bad++; $display("FAIL reset_rs got=%0b exp=0", rs); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_blank_frame();
    run_frame(-1, 0, -1);
    n_cmp++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL blank_busy_c1 got=%0b exp=1", busy_c1); end
    n_cmp++; if (first_load != 3) begin n_bad++; $display("FAIL blank_latency got=%0d exp=3", first_load); end
    n_cmp++; if (n_got != NB) begin n_bad++; $display("FAIL blank_count got=%0d exp=%0d", n_got, NB); end
    n_cmp++; if (done_c != 2 * NB + 2) begin n_bad++; $display("FAIL blank_done_cycle got=%0d exp=%0d", done_c, 2 * NB + 2); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL blank_busy_at_done got=%0b exp=0", busy_at_done); end
`ifdef HCMS_CTRL_WORD_EN
    n_cmp++; if (got_d[0] !== 8'h6F) begin n_bad++; $display("FAIL ctrl_byte got=%0h exp=6f", got_d[0]); end
    n_cmp++; if (got_rs[0] !== 1'b1) begin n_bad++; $display("FAIL ctrl_rs got=%0b exp=1", got_rs[0]); end
`endif
    for (int k = 0; k < 5 * NC; k++) begin
      n_cmp++;
      if (got_d[OFS+k] !== 8'h00 || got_rs[OFS+k] !== 1'b0) begin
        n_bad++; $display("FAIL blank_byte%0d got=%0h rs=%0b exp=0 rs=0", k, got_d[OFS+k], got_rs[OFS+k]);
      end
    end
  endtask

  task automatic test_font();
    logic [7:0] exp_b [20];
    exp_b = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E,
              8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E};
    write_char(2'd0, 8'h41);
    write_char(2'd1, 8'h61);
    write_char(2'd2, 8'h80);
    write_char(2'd3, 8'h30);
    run_frame(-1, 0, -1);
    n_cmp++; if (n_got != NB) begin n_bad++; $display("FAIL font_count got=%0d exp=%0d", n_got, NB); end
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (got_d[OFS+k] !== exp_b[k]) begin
        n_bad++; $display("FAIL font_byte%0d got=%0h exp=%0h", k, got_d[OFS+k], exp_b[k]);
      end
    end
  endtask

  task automatic test_stall();
    run_frame(3 + OFS, 7, -1);
    n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL stall_hold got=%0d changes exp=0", hold_err); end
    n_cmp++; if (n_got != NB) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", n_got, NB); end
    n_cmp++; if (done_c != 2 * NB + 9) begin n_bad++; $display("FAIL stall_done_cycle got=%0d exp=%0d", done_c, 2 * NB + 9); end
    n_cmp++; if (got_d[OFS+2] !== 8'h11) begin n_bad++; $display("FAIL stall_byte2 got=%0h exp=11", got_d[OFS+2]); end
    n_cmp++; if (got_d[OFS+3] !== 8'h11) begin n_bad++; $display("FAIL stall_byte3 got=%0h exp=11", got_d[OFS+3]); end
    n_cmp++; if (got_d[OFS+4] !== 8'h7E) begin n_bad++; $display("FAIL stall_byte4 got=%0h exp=7e", got_d[OFS+4]); end
    n_cmp++; if (got_d[OFS+5] !== 8'h7E) begin n_bad++; $display("FAIL stall_byte5 got=%0h exp=7e", got_d[OFS+5]); end
  endtask

  task automatic test_busy_ignore();
    int busy_cnt;
    run_frame(-1, 0, 5);
    n_cmp++; if (n_got != NB) begin n_bad++; $display("FAIL busy_ign_count got=%0d exp=%0d", n_got, NB); end
    n_cmp++; if (got_d[OFS+2] !== 8'h11) begin n_bad++; $display("FAIL busy_ign_write got=%0h exp=11", got_d[OFS+2]); end
    busy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || data_load !== 1'b0) busy_cnt++;
    end
    n_cmp++; if (busy_cnt != 0) begin n_bad++; $display("FAIL busy_ign_start got=%0d busy cycles exp=0", busy_cnt); end
    run_frame(-1, 0, -1);
    n_cmp++; if (got_d[OFS+2] !== 8'h11) begin n_bad++; $display("FAIL busy_ign_buffer got=%0h exp=11", got_d[OFS+2]); end
  endtask

  task automatic test_reset_mid();
    int cnt, idle_bad;
    logic busy_before;
    repeat (2) begin @(posedge clk); #1; end
    ser_ready = 1'b1; start = 1'b1; cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (data_load) cnt++;
      if (cnt == 10 + OFS) break;
    end
    n_cmp++; if (cnt != 10 + OFS) begin n_bad++; $display("FAIL rmid_reach got=%0d exp=%0d", cnt, 10 + OFS); end
    busy_before = busy;
    n_cmp++; if (busy_before !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got=%0b exp=1", busy_before); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (data_load !== 1'b0) begin n_bad++; $display("FAIL rmid_load got=%0b exp=0", data_load); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL rmid_data got=%0h exp=0", data); end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || data_load !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL rmid_idle got=%0d active cycles exp=0", idle_bad); end
    write_char(2'd0, 8'h48);
    run_frame(-1, 0, -1);
    n_cmp++; if (n_got != NB) begin n_bad++; $display("FAIL rmid_count got=%0d exp=%0d", n_got, NB); end
    n_cmp++; if (got_d[OFS+0] !== 8'h7F) begin n_bad++; $display("FAIL rmid_byte0 got=%0h exp=7f", got_d[OFS+0]); end
    n_cmp++; if (got_d[OFS+1] !== 8'h08) begin n_bad++; $display("FAIL rmid_byte1 got=%0h exp=08", got_d[OFS+1]); end
    n_cmp++; if (got_d[OFS+4] !== 8'h7F) begin n_bad++; $display("FAIL rmid_byte4 got=%0h exp=7f", got_d[OFS+4]); end
    n_cmp++; if (got_d[OFS+5] !== 8'h00) begin n_bad++; $display("FAIL rmid_byte5 got=%0h exp=00", got_d[OFS+5]); end
    n_cmp++; if (got_d[OFS+19] !== 8'h00) begin n_bad++; $display("FAIL rmid_byte19 got=%0h exp=00", got_d[OFS+19]); end
  endtask

  initial begin
    rstn = 1'b0; char_we = 1'b0; char_addr = 2'd0; char_d = 8'h00;
    start = 1'b0; ser_ready = 1'b1;
    test_reset();
    test_blank_frame();
    test_font();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
